// File: rtl/wash_phase_timer.sv
// wash_phase_timer: per-phase seconds timer returning the phase-finished handshake flag to the wash controller
module wash_phase_timer #(
  parameter int FILL_SEC    = 120,
  parameter int WASH_SEC    = 300,
  parameter int RINSE_SEC   = 120,
  parameter int SPIN_SEC    = 60,
  parameter int CLK_BASE_HZ = 1000000,
  parameter int PRE_W       = 24,
  parameter int SEC_W       = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       clk_freq,
  input  logic [2:0]       current_state,
  input  logic             cnt_rst_n,
  input  logic             double_wash,
  input  logic             timer_pause,
  output logic             state_finish,
  output logic             sec_tick,
  output logic [SEC_W-1:0] elapsed_sec
);
  localparam logic [2:0] IDLE = 3'b000, FILL = 3'b001, WASH = 3'b011, RINSE = 3'b111, SPIN = 3'b110;
  localparam logic [SEC_W-1:0] FILL_D = SEC_W'(FILL_SEC), SPIN_D = SEC_W'(SPIN_SEC);
  localparam logic [SEC_W-1:0] WASH_D = SEC_W'(WASH_SEC), WASH_DD = SEC_W'(2 * WASH_SEC);
  localparam logic [SEC_W-1:0] RINSE_D = SEC_W'(RINSE_SEC), RINSE_DD = SEC_W'(2 * RINSE_SEC);
  logic [PRE_W-1:0] pre, lim, lim_m1;
  logic [SEC_W-1:0] dur;
  logic [2:0] prev_state;
  logic dw_latch, active, clear, running, wrap;
  always_comb begin
    active  = current_state inside {FILL, WASH, RINSE, SPIN};
    clear   = !cnt_rst_n || current_state != prev_state || !active;
    running = !clear && !state_finish && !(current_state == SPIN && timer_pause);
    lim     = PRE_W'(CLK_BASE_HZ) << clk_freq;
    lim_m1  = lim - PRE_W'(1);
    wrap    = running && pre >= lim_m1;
    dur     = current_state == FILL  ? FILL_D :
              current_state == WASH  ? (dw_latch ? WASH_DD : WASH_D) :
              current_state == RINSE ? (dw_latch ? RINSE_DD : RINSE_D) : SPIN_D;
  end
  // elapsed_sec advances on the same edge that raises sec_tick, so a pause can never swallow a second
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre          <= '0;
      elapsed_sec  <= '0;
      state_finish <= 1'b0;
      sec_tick     <= 1'b0;
      prev_state   <= IDLE;
      dw_latch     <= 1'b0;
    end else begin
      prev_state <= current_state;
      dw_latch   <= current_state == IDLE ? 1'b0 :
                    (prev_state == IDLE && current_state == FILL) ? double_wash : dw_latch;
      if (clear) begin
        pre          <= '0;
        elapsed_sec  <= '0;
        state_finish <= 1'b0;
        sec_tick     <= 1'b0;
      end else begin
        sec_tick <= wrap;
        if (running) pre <= wrap ? '0 : pre + PRE_W'(1);
        if (wrap && elapsed_sec < dur) elapsed_sec <= elapsed_sec + SEC_W'(1);
        if (running && elapsed_sec >= dur) state_finish <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_wash_phase_timer.sv
// tb_wash_phase_timer: directed checks of prescaler, durations, double-wash, pause, handshake and reset
module tb_wash_phase_timer;
  localparam logic [2:0] IDLE = 3'b000, FILL = 3'b001, WASH = 3'b011, RINSE = 3'b111, SPIN = 3'b110;
  logic clk = 1'b0, rst_n = 1'b0, cnt_rst_n = 1'b1, double_wash = 1'b0, timer_pause = 1'b0;
  logic [1:0] clk_freq = 2'b00;
  logic [2:0] current_state = IDLE;
  logic state_finish, sec_tick;
  logic [3:0] elapsed_sec;
  int cmp = 0, errs = 0;
  wash_phase_timer #(.FILL_SEC(2), .WASH_SEC(3), .RINSE_SEC(2), .SPIN_SEC(2), .CLK_BASE_HZ(4),
                     .PRE_W(8), .SEC_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .clk_freq(clk_freq), .current_state(current_state),
    .cnt_rst_n(cnt_rst_n), .double_wash(double_wash), .timer_pause(timer_pause),
    .state_finish(state_finish), .sec_tick(sec_tick), .elapsed_sec(elapsed_sec));
  always #5 clk = ~clk;
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic test_reset;
    #3;
    cmp++; if ({state_finish, sec_tick, elapsed_sec} !== 6'd0) begin errs++; $display("FAIL reset: got fin=%b tick=%b el=%0d exp 0/0/0", state_finish, sec_tick, elapsed_sec); end
    step(1);
    rst_n = 1'b1;
    step(1);
  endtask
  task automatic test_timing;
    current_state = FILL;
    step(1);
    step(3);
    cmp++; if ({sec_tick, elapsed_sec} !== {1'b0, 4'd0}) begin errs++; $display("FAIL t1_pre: got tick=%b el=%0d exp 0/0", sec_tick, elapsed_sec); end
    step(1);
    cmp++; if ({sec_tick, elapsed_sec} !== {1'b1, 4'd1}) begin errs++; $display("FAIL t1_sec1: got tick=%b el=%0d exp 1/1", sec_tick, elapsed_sec); end
    step(1);
    cmp++; if (sec_tick !== 1'b0) begin errs++; $display("FAIL t1_pulse: got tick=%b exp 0", sec_tick); end
    step(3);
    cmp++; if ({state_finish, sec_tick, elapsed_sec} !== {2'b01, 4'd2}) begin errs++; $display("FAIL t1_sec2: got fin=%b tick=%b el=%0d exp 0/1/2", state_finish, sec_tick, elapsed_sec); end
    step(1);
    cmp++; if (state_finish !== 1'b1) begin errs++; $display("FAIL t1_fin: got %b exp 1", state_finish); end
    step(10);
    cmp++; if ({state_finish, elapsed_sec} !== {1'b1, 4'd2}) begin errs++; $display("FAIL t1_hold: got fin=%b el=%0d exp 1/2", state_finish, elapsed_sec); end
    cnt_rst_n = 1'b0;
    step(1);
    cnt_rst_n = 1'b1;
    cmp++; if ({state_finish, elapsed_sec} !== 5'd0) begin errs++; $display("FAIL t1_clr: got fin=%b el=%0d exp 0/0", state_finish, elapsed_sec); end
  endtask
  task automatic test_freq;
    current_state = IDLE;
    clk_freq = 2'b11;
    step(1);
    current_state = FILL;
    step(1);
    step(31);
    cmp++; if ({sec_tick, elapsed_sec} !== {1'b0, 4'd0}) begin errs++; $display("FAIL t2_pre: got tick=%b el=%0d exp 0/0", sec_tick, elapsed_sec); end
    step(1);
    cmp++; if ({sec_tick, elapsed_sec} !== {1'b1, 4'd1}) begin errs++; $display("FAIL t2_sec1: got tick=%b el=%0d exp 1/1", sec_tick, elapsed_sec); end
    step(32);
    cmp++; if ({state_finish, elapsed_sec} !== {1'b0, 4'd2}) begin errs++; $display("FAIL t2_sec2: got fin=%b el=%0d exp 0/2", state_finish, elapsed_sec); end
    step(1);
    cmp++; if (state_finish !== 1'b1) begin errs++; $display("FAIL t2_fin: got %b exp 1", state_finish); end
    clk_freq = 2'b00;
  endtask
  task automatic test_double_wash;
    current_state = IDLE;
    double_wash = 1'b1;
    step(1);
    current_state = FILL;
    step(1);
    double_wash = 1'b0;
    current_state = WASH;
    step(1);
    step(24);
    cmp++; if ({state_finish, elapsed_sec} !== {1'b0, 4'd6}) begin errs++; $display("FAIL t3_wash: got fin=%b el=%0d exp 0/6", state_finish, elapsed_sec); end
    step(1);
    cmp++; if (state_finish !== 1'b1) begin errs++; $display("FAIL t3_wash_fin: got %b exp 1", state_finish); end
    current_state = RINSE;
    step(1);
    step(16);
    cmp++; if ({state_finish, elapsed_sec} !== {1'b0, 4'd4}) begin errs++; $display("FAIL t3_rinse: got fin=%b el=%0d exp 0/4", state_finish, elapsed_sec); end
    step(1);
    cmp++; if (state_finish !== 1'b1) begin errs++; $display("FAIL t3_rinse_fin: got %b exp 1", state_finish); end
  endtask
  task automatic test_pause;
    current_state = SPIN;
    step(1);
    step(2);
    timer_pause = 1'b1;
    step(20);
    cmp++; if ({sec_tick, elapsed_sec} !== {1'b0, 4'd0}) begin errs++; $display("FAIL t4_frozen: got tick=%b el=%0d exp 0/0", sec_tick, elapsed_sec); end
    timer_pause = 1'b0;
    step(1);
    cmp++; if (elapsed_sec !== 4'd0) begin errs++; $display("FAIL t4_resume0: got el=%0d exp 0", elapsed_sec); end
    step(1);
    cmp++; if ({sec_tick, elapsed_sec} !== {1'b1, 4'd1}) begin errs++; $display("FAIL t4_partial: got tick=%b el=%0d exp 1/1", sec_tick, elapsed_sec); end
    step(4);
    cmp++; if ({state_finish, elapsed_sec} !== {1'b0, 4'd2}) begin errs++; $display("FAIL t4_sec2: got fin=%b el=%0d exp 0/2", state_finish, elapsed_sec); end
    step(1);
    cmp++; if (state_finish !== 1'b1) begin errs++; $display("FAIL t4_fin: got %b exp 1", state_finish); end
    current_state = WASH;
    timer_pause = 1'b1;
    step(1);
    step(4);
    cmp++; if (elapsed_sec !== 4'd1) begin errs++; $display("FAIL t4_wash_pause: got el=%0d exp 1", elapsed_sec); end
    timer_pause = 1'b0;
  endtask
  task automatic test_handshake;
    logic [2:0] codes [5] = '{FILL, WASH, RINSE, SPIN, IDLE};
    int durs [4] = '{2, 3, 2, 2};
    int n, pulses;
    pulses = 0;
    current_state = IDLE;
    step(1);
    current_state = FILL;
    step(1);
    for (int p = 0; p < 4; p++) begin
      cmp++; if ({state_finish, elapsed_sec} !== 5'd0) begin errs++; $display("FAIL t5_entry%0d: got fin=%b el=%0d exp 0/0", p, state_finish, elapsed_sec); end
      n = 0;
      while (!state_finish && n < 100) begin step(1); n++; end
      if (state_finish) pulses++;
      cmp++; if (n !== 4 * durs[p] + 1 || elapsed_sec !== 4'(durs[p])) begin errs++; $display("FAIL t5_phase%0d: got cycles=%0d el=%0d exp %0d/%0d", p, n, elapsed_sec, 4 * durs[p] + 1, durs[p]); end
      current_state = codes[p + 1];
      cnt_rst_n = 1'b0;
      step(1);
      cnt_rst_n = 1'b1;
      cmp++; if (state_finish !== 1'b0) begin errs++; $display("FAIL t5_ack%0d: got fin=%b exp 0", p, state_finish); end
    end
    cmp++; if (pulses !== 4) begin errs++; $display("FAIL t5_pulses: got %0d exp 4", pulses); end
    step(20);
    cmp++; if ({state_finish, sec_tick, elapsed_sec} !== 6'd0) begin errs++; $display("FAIL t5_idle: got fin=%b tick=%b el=%0d exp 0/0/0", state_finish, sec_tick, elapsed_sec); end
    current_state = 3'b100;
    step(20);
    cmp++; if ({state_finish, sec_tick, elapsed_sec} !== 6'd0) begin errs++; $display("FAIL t5_undef: got fin=%b tick=%b el=%0d exp 0/0/0", state_finish, sec_tick, elapsed_sec); end
  endtask
  task automatic test_back_to_back;
    current_state = IDLE;
    step(1);
    current_state = FILL;
    step(1);
    current_state = WASH;
    step(1);
    step(8);
    cmp++; if ({sec_tick, elapsed_sec} !== {1'b1, 4'd2}) begin errs++; $display("FAIL t6_pre_rst: got tick=%b el=%0d exp 1/2", sec_tick, elapsed_sec); end
    #2 rst_n = 1'b0;
    #1;
    cmp++; if ({state_finish, sec_tick, elapsed_sec} !== 6'd0) begin errs++; $display("FAIL t6_async_rst: got fin=%b tick=%b el=%0d exp 0/0/0", state_finish, sec_tick, elapsed_sec); end
    #1 rst_n = 1'b1;
    current_state = FILL;
    step(1);
    step(3);
    cnt_rst_n = 1'b0;
    step(1);
    cnt_rst_n = 1'b1;
    cmp++; if ({sec_tick, elapsed_sec} !== 5'd0) begin errs++; $display("FAIL t6_clr_wins: got tick=%b el=%0d exp 0/0", sec_tick, elapsed_sec); end
    step(4);
    cmp++; if ({sec_tick, elapsed_sec} !== {1'b1, 4'd1}) begin errs++; $display("FAIL t6_restart: got tick=%b el=%0d exp 1/1", sec_tick, elapsed_sec); end
  endtask
  initial begin
    test_reset();
    test_timing();
    test_freq();
    test_double_wash();
    test_pause();
    test_handshake();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
    $finish;
  end
endmodule
